apb_txn_monitor: RTL and testbench

//  Passive, parametrised APB bus monitor for the ECC encoder/decoder environment.
//  - Protocol FSM tracks APB setup/access phases and flags protocol violations.
//  - Completed transfers are captured into a show-ahead FIFO, drained by the checker.
//  - Keeps saturating statistics: writes, reads, operation_done events, error histogram.
//  - Never drives the bus; sits beside the DUT on the checker/coverage side.

---
 rtl/apb_txn_monitor_if.sv | 17 +
 rtl/apb_txn_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_apb_txn_monitor.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_txn_monitor_if.sv
// APB signal bundle shared by the bus master, the slave and passive observers.
// The monitor modport only listens and drives nothing.
interface apb_txn_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              penable;
  logic              psel;
  logic              pwrite;
  logic [DATA_W-1:0] prdata;

  modport master  (output paddr, pwdata, penable, psel, pwrite, input prdata);
  modport slave   (input paddr, pwdata, penable, psel, pwrite, output prdata);
  modport monitor (input paddr, pwdata, penable, psel, pwrite, prdata);
endinterface

// File: rtl/apb_txn_monitor.sv
// Passive APB monitor: protocol FSM with sticky violation flags, show-ahead capture
// FIFO of completed transfers, and saturating transfer / done / error statistics.
module apb_txn_monitor #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  apb_txn_monitor_if.monitor             bus,
  input  logic                           operation_done,
  input  logic [1:0]                     num_of_errors,
  input  logic                           clr_stats,
  input  logic                           txn_rd_en,
  output logic                           txn_valid,
  output logic [AMBA_ADDR_WIDTH-1:0]     txn_addr,
  output logic [AMBA_WORD-1:0]           txn_data,
  output logic                           txn_write,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           overflow,
  output logic                           proto_err,
  output logic [1:0]                     proto_err_code,
  output logic [CNT_WIDTH-1:0]           wr_cnt,
  output logic [CNT_WIDTH-1:0]           rd_cnt,
  output logic [CNT_WIDTH-1:0]           done_cnt,
  output logic [CNT_WIDTH-1:0]           err1_cnt,
  output logic [CNT_WIDTH-1:0]           err2_cnt,
  output logic [1:0]                     dbg_state
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]        FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]        PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t                     r_state, w_state_nxt;
  logic [AMBA_ADDR_WIDTH-1:0] r_lat_addr;
  logic [AMBA_WORD-1:0]       r_lat_wdata;
  logic                       r_lat_write;
  logic                       w_latch, w_capture, w_viol, w_match;
  logic [1:0]                 w_viol_code;

  assign dbg_state = r_state;
  assign w_match   = (bus.paddr == r_lat_addr) && (bus.pwrite == r_lat_write) &&
                     (bus.pwdata == r_lat_wdata);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_lat_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_lat_addr  <= bus.paddr;
        r_lat_wdata <= bus.pwdata;
        r_lat_write <= bus.pwrite;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_viol      = 1'b0;
    w_viol_code = 2'd0;
    case (r_state)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          w_state_nxt = SETUP;
          w_latch     = 1'b1;
        end else if (bus.psel && bus.penable) begin
          w_viol      = 1'b1;
          w_viol_code = 2'd1;
        end
      end
      SETUP: begin
        if (bus.psel && bus.penable) begin
          // A field change is flagged but the transfer still completes and is captured.
          w_capture   = 1'b1;
          w_state_nxt = ACCESS;
          if (!w_match) begin
            w_viol      = 1'b1;
            w_viol_code = 2'd3;
          end
        end else begin
          w_viol      = 1'b1;
          w_viol_code = 2'd2;
          if (bus.psel) begin
            w_latch     = 1'b1;
            w_state_nxt = SETUP;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      ACCESS: begin
        if (bus.psel && !bus.penable) begin
          w_state_nxt = SETUP;
          w_latch     = 1'b1;
        end else if (bus.psel && bus.penable) begin
          w_viol      = 1'b1;
          w_viol_code = 2'd1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture FIFO; valid/ready: a pop happens only when txn_rd_en meets txn_valid.
  logic [AMBA_ADDR_WIDTH-1:0] r_mem_addr  [FIFO_DEPTH];
  logic [AMBA_WORD-1:0]       r_mem_data  [FIFO_DEPTH];
  logic                       r_mem_write [FIFO_DEPTH];
  logic [PW-1:0]              r_wptr, r_rptr;
  logic [CW-1:0]              r_count;
  logic                       w_pop, w_full, w_push_ok;

  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = txn_rd_en && (r_count != '0);
  assign w_push_ok  = w_capture && (!w_full || w_pop);
  assign txn_valid  = (r_count != '0);
  assign fifo_count = r_count;
  assign txn_addr   = r_mem_addr[r_rptr];
  assign txn_data   = r_mem_data[r_rptr];
  assign txn_write  = r_mem_write[r_rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_addr[i]  <= '0;
        r_mem_data[i]  <= '0;
        r_mem_write[i] <= 1'b0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem_addr[r_wptr]  <= bus.paddr;
        r_mem_data[r_wptr]  <= bus.pwrite ? bus.pwdata : bus.prdata;
        r_mem_write[r_wptr] <= bus.pwrite;
        r_wptr              <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_ONE;
  endfunction

  logic r_prev_done, w_done_edge;
  assign w_done_edge = operation_done && !r_prev_done;

  // Statistics and sticky flags; clr_stats wins over any same-cycle update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_done    <= 1'b0;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      done_cnt       <= '0;
      err1_cnt       <= '0;
      err2_cnt       <= '0;
      overflow       <= 1'b0;
      proto_err      <= 1'b0;
      proto_err_code <= 2'd0;
    end else begin
      r_prev_done <= operation_done;
      if (clr_stats) begin
        wr_cnt         <= '0;
        rd_cnt         <= '0;
        done_cnt       <= '0;
        err1_cnt       <= '0;
        err2_cnt       <= '0;
        overflow       <= 1'b0;
        proto_err      <= 1'b0;
        proto_err_code <= 2'd0;
      end else begin
        if (w_capture && bus.pwrite)  wr_cnt <= sat_inc(wr_cnt);
        if (w_capture && !bus.pwrite) rd_cnt <= sat_inc(rd_cnt);
        if (w_done_edge) begin
          done_cnt <= sat_inc(done_cnt);
          if (num_of_errors == 2'd1) err1_cnt <= sat_inc(err1_cnt);
          if (num_of_errors == 2'd2) err2_cnt <= sat_inc(err2_cnt);
        end
        if (w_capture && w_full && !w_pop) overflow <= 1'b1;
        if (w_viol) begin
          proto_err <= 1'b1;
          if (!proto_err) proto_err_code <= w_viol_code;
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_txn_monitor.sv
// Directed bench for apb_txn_monitor: APB transfers, FIFO boundaries, violations, stats.
module tb_apb_txn_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic        operation_done, clr_stats, txn_rd_en;
  logic [1:0]  num_of_errors;
  logic        txn_valid, txn_write, overflow, proto_err;
  logic [31:0] txn_addr, txn_data;
  logic [3:0]  fifo_count;
  logic [1:0]  proto_err_code, dbg_state;
  logic [15:0] wr_cnt, rd_cnt, done_cnt, err1_cnt, err2_cnt;
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];

  apb_txn_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_txn_monitor #(.AMBA_ADDR_WIDTH(32), .AMBA_WORD(32), .FIFO_DEPTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .operation_done(operation_done), .num_of_errors(num_of_errors),
    .clr_stats(clr_stats), .txn_rd_en(txn_rd_en),
    .txn_valid(txn_valid), .txn_addr(txn_addr), .txn_data(txn_data), .txn_write(txn_write),
    .fifo_count(fifo_count), .overflow(overflow), .proto_err(proto_err),
    .proto_err_code(proto_err_code), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
    .done_cnt(done_cnt), .err1_cnt(err1_cnt), .err2_cnt(err2_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle at the falling edge; the DUT samples at the following rising edge.
  task automatic drive(input logic s, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
    bus.psel = s; bus.penable = e; bus.pwrite = w;
    bus.paddr = a; bus.pwdata = d; bus.prdata = rd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, 1'b1, a, d, 32'h0);
    drive(1'b1, 1'b1, 1'b1, a, d, 32'h0);
  endtask

  task automatic pop();
    txn_rd_en = 1'b1;
    @(negedge clk);
    txn_rd_en = 1'b0;
  endtask

  task automatic clear();
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
  endtask

  task automatic pulse_done(input logic [1:0] n, input int high_cycles);
    num_of_errors = n;
    operation_done = 1'b1;
    repeat (high_cycles) @(negedge clk);
    operation_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; operation_done = 1'b0; num_of_errors = 2'd0;
    clr_stats = 1'b0; txn_rd_en = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.prdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", txn_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b1;
    @(negedge clk);

    // Write then read, both entries visible in order.
    apb_wr(32'h10, 32'hCAFE);
    idle();
    drive(1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 32'hBEEF);
    idle();
    chk("wr_rd_count", fifo_count, 2);
    chk("wr_head_addr", txn_addr, 32'h10);
    chk("wr_head_data", txn_data, 32'hCAFE);
    chk("wr_head_dir", txn_write, 1);
    pop();
    chk("rd_head_addr", txn_addr, 32'h14);
    chk("rd_head_data", txn_data, 32'hBEEF);
    chk("rd_head_dir", txn_write, 0);
    pop();
    chk("drained_valid", txn_valid, 0);
    chk("wr_cnt_1", wr_cnt, 1);
    chk("rd_cnt_1", rd_cnt, 1);
    chk("no_proto_1", proto_err, 0);

    // Ten back-to-back writes into an 8-deep FIFO: two dropped.
    for (int i = 0; i < 10; i++) begin
      apb_wr(32'h100 + 32'(4 * i), 32'(i + 1));
      if (i < 8) exp_q.push_back(32'(i + 1));
    end
    idle();
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_wr_cnt", wr_cnt, 11);
    chk("b2b_no_proto", proto_err, 0);
    while (exp_q.size() != 0) begin
      chk("ovf_drain_data", txn_data, exp_q.pop_front());
      pop();
    end
    chk("ovf_drained", txn_valid, 0);
    pop();
    chk("pop_empty_count", fifo_count, 0);

    clear();
    chk("clr_overflow", overflow, 0);
    chk("clr_wr_cnt", wr_cnt, 0);

    // Full FIFO: pop and capture in the same cycle.
    for (int i = 0; i < 8; i++) begin
      apb_wr(32'h200 + 32'(i), 32'h200 + 32'(i));
      if (i > 0) exp_q.push_back(32'h200 + 32'(i));
    end
    exp_q.push_back(32'h300);
    chk("full_count", fifo_count, 8);
    drive(1'b1, 1'b0, 1'b1, 32'h300, 32'h300, 32'h0);
    txn_rd_en = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h300, 32'h300, 32'h0);
    txn_rd_en = 1'b0;
    idle();
    chk("pp_count", fifo_count, 8);
    chk("pp_no_ovf", overflow, 0);
    while (exp_q.size() != 0) begin
      chk("pp_drain_data", txn_data, exp_q.pop_front());
      pop();
    end
    chk("pp_drained", txn_valid, 0);

    // Enable without setup, then a setup abandoned: first code is kept.
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0);
    idle();
    chk("v1_flag", proto_err, 1);
    chk("v1_code", proto_err_code, 1);
    drive(1'b1, 1'b0, 1'b1, 32'h44, 32'h1, 32'h0);
    idle();
    chk("v2_code_kept", proto_err_code, 1);
    chk("v2_state", dbg_state, 0);
    chk("v2_no_capture", fifo_count, 0);
    clear();
    chk("clr_proto", proto_err, 0);
    chk("clr_code", proto_err_code, 0);

    // Address changes between setup and access.
    drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h55, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h24, 32'h55, 32'h0);
    idle();
    chk("v3_flag", proto_err, 1);
    chk("v3_code", proto_err_code, 3);
    chk("v3_count", fifo_count, 1);
    chk("v3_addr", txn_addr, 32'h24);
    pop();

    // Done pulses with error counts 1, 2, 3; last pulse held two cycles.
    clear();
    pulse_done(2'd1, 1);
    pulse_done(2'd2, 1);
    pulse_done(2'd3, 2);
    chk("done_cnt", done_cnt, 3);
    chk("err1_cnt", err1_cnt, 1);
    chk("err2_cnt", err2_cnt, 1);
    clear();
    chk("clr_done", done_cnt, 0);
    chk("clr_err1", err1_cnt, 0);
    chk("clr_err2", err2_cnt, 0);

    // clr_stats beats a done edge in the same cycle.
    num_of_errors = 2'd1;
    operation_done = 1'b1;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    operation_done = 1'b0;
    @(negedge clk);
    chk("clr_beats_done", done_cnt, 0);
    chk("clr_beats_err1", err1_cnt, 0);

    // Reset during setup; the access right after release is an orphan.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h50; bus.pwdata = 32'h77;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_state", dbg_state, 0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h50, 32'h77, 32'h0);
    idle();
    chk("midrst_proto", proto_err, 1);
    chk("midrst_code", proto_err_code, 1);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_wr_cnt", wr_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "bench time limit");
  end
endmodule
